// File: rtl/boot_loader.sv
// Boot-stream loader: parses a word-count header, copies the payload into
// instruction memory byte by byte, then releases the CPU once the XOR checksum matches.
//
// state     | meaning
// ----------+--------------------------------------------------------
// S_HDR_HI  | waiting for high byte of word count
// S_HDR_LO  | waiting for low byte of word count; range check
// S_PAYLOAD | streaming payload bytes into imem, accumulating XOR
// S_CSUM    | waiting for checksum byte
// S_DONE    | image verified, CPU released (sticky until rst)
// S_ERR     | length or checksum failure, CPU held (sticky until rst)
module boot_loader #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [7:0]        in_byte,
  output logic              in_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_waddr,
  output logic [7:0]        imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error,
  output logic [15:0]       word_count
);

  localparam logic [2:0] S_HDR_HI  = 3'd0;
  localparam logic [2:0] S_HDR_LO  = 3'd1;
  localparam logic [2:0] S_PAYLOAD = 3'd2;
  localparam logic [2:0] S_CSUM    = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;
  localparam logic [2:0] S_ERR     = 3'd5;

  localparam logic [16:0] DEPTH_N = 17'(DEPTH_WORDS);

  logic [2:0]  state;
  logic [17:0] byte_cnt;
  logic [7:0]  csum;
  logic        accept;
  logic [15:0] hdr_n;
  logic [17:0] last_idx;

  assign accept   = in_valid & in_ready;
  assign hdr_n    = {word_count[15:8], in_byte};
  // Only meaningful while in S_PAYLOAD, where word_count is known to be non-zero.
  assign last_idx = {word_count, 2'b00} - 18'd1;

  assign in_ready = (state == S_HDR_HI) || (state == S_HDR_LO) ||
                    (state == S_PAYLOAD) || (state == S_CSUM);
  assign done     = (state == S_DONE);
  assign error    = (state == S_ERR);
  assign cpu_rst  = (state != S_DONE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_HDR_HI;
      word_count <= 16'd0;
      byte_cnt   <= 18'd0;
      csum       <= 8'd0;
      imem_we    <= 1'b0;
      imem_waddr <= '0;
      imem_wdata <= 8'd0;
    end else begin
      imem_we <= 1'b0;
      if (accept) begin
        case (state)
          S_HDR_HI: begin
            word_count[15:8] <= in_byte;
            state            <= S_HDR_LO;
          end
          S_HDR_LO: begin
            word_count[7:0] <= in_byte;
            if ({1'b0, hdr_n} > DEPTH_N)
              state <= S_ERR;
            else if (hdr_n == 16'd0)
              state <= S_CSUM;
            else
              state <= S_PAYLOAD;
          end
          S_PAYLOAD: begin
            // Range check on the header keeps byte_cnt below 4*DEPTH_WORDS here.
            imem_we    <= 1'b1;
            imem_waddr <= byte_cnt[ADDR_W-1:0];
            imem_wdata <= in_byte;
            csum       <= csum ^ in_byte;
            byte_cnt   <= byte_cnt + 18'd1;
            if (byte_cnt == last_idx)
              state <= S_CSUM;
          end
          S_CSUM: begin
            state <= (in_byte == csum) ? S_DONE : S_ERR;
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_boot_loader.sv
// Self-checking bench for boot_loader: directed and random boot streams are
// compared against a stream-level model of the expected writes and outcome.
module tb_boot_loader;

  typedef logic [7:0] u8;

  localparam int DEPTH_WORDS = 256;
  localparam int ADDR_W      = 10;

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic [7:0]        in_byte;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_waddr;
  logic [7:0]        imem_wdata;
  logic              cpu_rst;
  logic              done;
  logic              error;
  logic [15:0]       word_count;

  int total = 0;
  int bad   = 0;

  int act_addr[$];
  int act_data[$];
  int exp_addr[$];
  int exp_data[$];

  boot_loader #(.DEPTH_WORDS(DEPTH_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_byte    (in_byte),
    .in_ready   (in_ready),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  // Each cycle with imem_we high is one write pulse.
  always @(negedge clk) begin
    if (imem_we) begin
      act_addr.push_back(int'(imem_waddr));
      act_data.push_back(int'(imem_wdata));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    @(negedge clk);
    rst = 1'b0;
    act_addr.delete();
    act_data.delete();
  endtask

  // Presents one byte for exactly one cycle after an optional idle gap.
  task automatic send_byte(input u8 b, input int gap);
    int g;
    g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
    repeat (g) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_byte  = u8'($urandom);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
  endtask

  // Stream-level model: header, payload of 4*N bytes, XOR checksum; stop at first verdict.
  task automatic model(input u8 s[$], output bit md, output bit me, output logic [15:0] mwc);
    int n;
    u8 cs;
    md = 1'b0;
    me = 1'b0;
    mwc = 16'h0;
    exp_addr.delete();
    exp_data.delete();
    if (s.size() >= 1) mwc[15:8] = s[0];
    if (s.size() < 2) return;
    mwc[7:0] = s[1];
    n = int'(mwc);
    if (n > DEPTH_WORDS) begin
      me = 1'b1;
      return;
    end
    cs = 8'h00;
    for (int i = 0; i < 4 * n && 2 + i < s.size(); i++) begin
      exp_addr.push_back(i);
      exp_data.push_back(int'(s[2 + i]));
      cs = cs ^ s[2 + i];
    end
    if (s.size() < 3 + 4 * n) return;
    if (s[2 + 4 * n] == cs) md = 1'b1;
    else me = 1'b1;
  endtask

  task automatic run_stream(input string name, input u8 s[$], input int gap, input bit do_rst);
    bit md, me;
    logic [15:0] mwc;
    int nw;
    if (do_rst) do_reset();
    foreach (s[i]) send_byte(s[i], gap);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    model(s, md, me, mwc);
    chk({name, ".done"},     32'(done),       32'(md));
    chk({name, ".error"},    32'(error),      32'(me));
    chk({name, ".cpu_rst"},  32'(cpu_rst),    32'(!md));
    chk({name, ".in_ready"}, 32'(in_ready),   32'(!(md || me)));
    chk({name, ".wc"},       32'(word_count), 32'(mwc));
    chk({name, ".excl"},     32'(done & error), 32'd0);
    chk({name, ".wr_cnt"},   32'(act_addr.size()), 32'(exp_addr.size()));
    nw = (act_addr.size() < exp_addr.size()) ? act_addr.size() : exp_addr.size();
    for (int i = 0; i < nw; i++) begin
      chk({name, ".wr_addr"}, 32'(act_addr[i]), 32'(exp_addr[i]));
      chk({name, ".wr_data"}, 32'(act_data[i]), 32'(exp_data[i]));
    end
  endtask

  initial begin
    u8 s[$];
    int n;
    u8 cs;

    rst      = 1'b1;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.in_ready", 32'(in_ready),   32'd1);
    chk("rst.imem_we",  32'(imem_we),    32'd0);
    chk("rst.waddr",    32'(imem_waddr), 32'd0);
    chk("rst.wdata",    32'(imem_wdata), 32'd0);
    chk("rst.cpu_rst",  32'(cpu_rst),    32'd1);
    chk("rst.done",     32'(done),       32'd0);
    chk("rst.error",    32'(error),      32'd0);
    chk("rst.wc",       32'(word_count), 32'd0);
    rst = 1'b0;

    run_stream("good",   '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 0, 1'b1);
    run_stream("badcs",  '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23}, 0, 1'b1);
    run_stream("n257",   '{8'h01, 8'h01, 8'h11, 8'h22}, 0, 1'b1);
    run_stream("n0ok",   '{8'h00, 8'h00, 8'h00}, 0, 1'b1);
    run_stream("n0bad",  '{8'h00, 8'h00, 8'h5A}, 0, 1'b1);
    run_stream("toggle", '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22, 8'h11, 8'h33}, 1, 1'b1);

    // Reset lands together with a payload handshake: that byte must not be written.
    do_reset();
    send_byte(8'h00, 0);
    send_byte(8'h01, 0);
    send_byte(8'hDE, 0);
    @(negedge clk);
    rst      = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'hAD;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("midrst.wr_cnt",   32'(act_addr.size()), 32'd1);
    chk("midrst.wc",       32'(word_count),      32'd0);
    chk("midrst.in_ready", 32'(in_ready),        32'd1);
    act_addr.delete();
    act_data.delete();
    run_stream("midrst", '{8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22}, 0, 1'b0);

    // Largest legal image fills every imem byte address.
    s.delete();
    s.push_back(8'h01);
    s.push_back(8'h00);
    cs = 8'h00;
    for (int i = 0; i < 4 * DEPTH_WORDS; i++) begin
      s.push_back(u8'($urandom));
      cs = cs ^ s[s.size() - 1];
    end
    s.push_back(cs);
    run_stream("full", s, 0, 1'b1);

    for (int it = 0; it < 24; it++) begin
      s.delete();
      if (it % 7 == 3) begin
        n = 257 + int'($urandom_range(0, 600));
        s.push_back(u8'(n >> 8));
        s.push_back(u8'(n & 255));
        for (int j = 0; j < 3; j++) s.push_back(u8'($urandom));
      end else begin
        n = int'($urandom_range(0, 6));
        s.push_back(8'h00);
        s.push_back(u8'(n));
        cs = 8'h00;
        for (int j = 0; j < 4 * n; j++) begin
          s.push_back(u8'($urandom));
          cs = cs ^ s[s.size() - 1];
        end
        if ($urandom_range(0, 3) == 0) s.push_back(cs ^ u8'($urandom_range(1, 255)));
        else s.push_back(cs);
        for (int j = 0; j < int'($urandom_range(0, 2)); j++) s.push_back(u8'($urandom));
      end
      run_stream("rand", s, -1, 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
